// File: rtl/ledwalk_pkg.sv
// Shared definitions for the Wishbone LED walker: register map, CTRL/STATUS
// bit positions, mode encoding, walk FSM state codes and the shadow config.
package ledwalk_pkg;

  // Register select on the single address line
  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_DIV  = 1'b1;

  // CTRL write bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_OVR     = 3;
  localparam int CTRL_REP_LSB = 4;

  // STATUS read bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_MODE    = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_OVR     = 3;
  localparam int STAT_REP_LSB = 4;
  localparam int STAT_POS_LSB = 8;
  localparam int STAT_POS_W   = 8;

  // Width of the repeat field (pass count minus one)
  localparam int REP_W = 4;

  // Walk mode encoding
  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_ONEWAY = 1'b1;

  // Walk FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  // Walk configuration as captured from a CTRL write
  typedef struct packed {
    logic             mode;
    logic [REP_W-1:0] reps;
  } walk_cfg_t;

endpackage

// File: rtl/walk_step_div.sv
// Step-rate divider for the LED walker: while running, counts clocks and
// raises a step pulse once the count reaches the live divider value. The
// count restarts at every step, so each step lasts div+1 clocks, and a
// lowered divider ends the current step as soon as the compare sees it.
module walk_step_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] count_reg;

  // Compare against the live divider so a mid-step write takes effect at once
  assign step = run && (count_reg >= div);

  // Count clocks within the current step; idle or step end restarts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (!run || step) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ledwalker_wb.sv
// Wishbone-pipelined LED walker. Sweeps one lit LED across NLEDS outputs in
// bounce or one-way mode, REPEAT+1 passes back to back, at a programmable
// step rate. Starts come from a CTRL write or a synchronised push-button.
module ledwalker_wb
  import ledwalk_pkg::*;
#(
  parameter int          NLEDS       = 8,
  parameter int          DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 5_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic             i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [NLEDS-1:0] o_led,
  output logic             o_int
);

  localparam int POS_W = (NLEDS > 1) ? $clog2(NLEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NLEDS - 1);

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [POS_W-1:0] pos_reg;
  logic [REP_W-1:0] rep_reg;
  logic             mode_reg;
  walk_cfg_t        cfg_reg;
  logic [DIV_W-1:0] div_reg;
  logic             done_reg;
  logic             overrun_reg;
  logic             int_reg;
  logic [NLEDS-1:0] led_reg;
  logic             ack_reg;
  logic [31:0]      rdata_reg;
  logic [2:0]       btn_sync_reg;

  // ---------------------------------------------------------------------
  // Next-state / decode signals
  // ---------------------------------------------------------------------
  logic [1:0]       state_next;
  logic [POS_W-1:0] pos_next;
  logic [REP_W-1:0] rep_next;
  logic             mode_next;
  logic             finish;
  logic [NLEDS-1:0] led_next;

  logic             req;
  logic             wr_ctrl;
  logic             wr_div;
  logic             busy;
  logic             btn_rise;
  logic             bus_start;
  logic             btn_start;
  logic             start_req;
  logic             start_ok;
  logic             overrun_set;
  logic             step;
  walk_cfg_t        bus_cfg;
  walk_cfg_t        start_cfg;
  logic [31:0]      status_word;
  logic [31:0]      div_word;
  logic             unused_ok;

  // Data bits above the CTRL field and the divider width carry no meaning
  assign unused_ok = &{1'b0, i_wb_data};

  // ---------------------------------------------------------------------
  // Bus decode and start arbitration
  // ---------------------------------------------------------------------
  assign req       = i_wb_stb && i_wb_cyc;
  assign wr_ctrl   = req && i_wb_we && (i_wb_addr == ADDR_CTRL);
  assign wr_div    = req && i_wb_we && (i_wb_addr == ADDR_DIV);
  assign busy      = (state_reg != ST_IDLE);

  assign bus_cfg.mode = i_wb_data[CTRL_MODE];
  assign bus_cfg.reps = i_wb_data[CTRL_REP_LSB +: REP_W];

  // The bus wins a same-cycle tie; the button event is simply dropped
  assign bus_start   = wr_ctrl && i_wb_data[CTRL_START];
  assign btn_start   = btn_rise && !bus_start;
  assign start_req   = bus_start || btn_start;
  assign start_ok    = start_req && !busy;
  assign overrun_set = start_req && busy;

  // A bus start uses the config in the same write; a button start the shadow
  assign start_cfg = bus_start ? bus_cfg : cfg_reg;

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_reg;
  assign o_wb_data  = rdata_reg;
  assign o_led      = led_reg;
  assign o_int      = int_reg;

  // ---------------------------------------------------------------------
  // Button synchroniser: two flops for metastability, a third for edges
  // ---------------------------------------------------------------------
  assign btn_rise = btn_sync_reg[1] && !btn_sync_reg[2];

  // Shift the raw button through the synchroniser chain
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      btn_sync_reg <= '0;
    end else begin
      btn_sync_reg <= {btn_sync_reg[1:0], i_btn};
    end
  end

  // ---------------------------------------------------------------------
  // Step divider
  // ---------------------------------------------------------------------
  walk_step_div #(
    .DIV_W (DIV_W)
  ) u_step_div (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .run   (busy),
    .div   (div_reg),
    .step  (step)
  );

  // ---------------------------------------------------------------------
  // Position / direction / repeat FSM
  // ---------------------------------------------------------------------
  // Decide the next walk position; a pass end either reloads LED0 for the
  // next pass with no idle gap or finishes the walk
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    rep_next   = rep_reg;
    mode_next  = mode_reg;
    finish     = 1'b0;
    if (start_ok) begin
      state_next = ST_UP;
      pos_next   = '0;
      rep_next   = start_cfg.reps;
      mode_next  = start_cfg.mode;
    end else if (step) begin
      case (state_reg)
        ST_UP: begin
          if (pos_reg != POS_LAST) begin
            pos_next = pos_reg + POS_W'(1);
          end else if (mode_reg == MODE_ONEWAY) begin
            if (rep_reg == '0) begin
              finish = 1'b1;
            end else begin
              rep_next = rep_reg - REP_W'(1);
              pos_next = '0;
            end
          end else begin
            state_next = ST_DOWN;
            pos_next   = pos_reg - POS_W'(1);
          end
        end
        ST_DOWN: begin
          if (pos_reg != '0) begin
            pos_next = pos_reg - POS_W'(1);
          end else if (rep_reg == '0) begin
            finish = 1'b1;
          end else begin
            // LED0 stays lit for one more step as the next pass begins
            rep_next   = rep_reg - REP_W'(1);
            state_next = ST_UP;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
      if (finish) begin
        state_next = ST_IDLE;
        pos_next   = '0;
      end
    end
  end

  // Register the walk FSM
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_IDLE;
      pos_reg   <= '0;
      rep_reg   <= '0;
      mode_reg  <= MODE_BOUNCE;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      rep_reg   <= rep_next;
      mode_reg  <= mode_next;
    end
  end

  // One-hot decode of the upcoming position, registered so it lines up
  // with busy and the position field
  for (genvar gi = 0; gi < NLEDS; gi++) begin : g_led
    assign led_next[gi] = (state_next != ST_IDLE) && (pos_next == POS_W'(gi));
  end

  // Drive the LEDs and the completion pulse from registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      led_reg <= '0;
      int_reg <= 1'b0;
    end else begin
      led_reg <= led_next;
      int_reg <= finish;
    end
  end

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  // Every CTRL write refreshes the shadow config; DIV keeps its low bits
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cfg_reg.mode <= MODE_BOUNCE;
      cfg_reg.reps <= '0;
      div_reg      <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (wr_ctrl) begin
        cfg_reg <= bus_cfg;
      end
      if (wr_div) begin
        div_reg <= i_wb_data[DIV_W-1:0];
      end
    end
  end

  // Sticky flags: a hardware set beats a same-cycle write-one-to-clear
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (finish) begin
        done_reg <= 1'b1;
      end else if (wr_ctrl && i_wb_data[CTRL_DONE]) begin
        done_reg <= 1'b0;
      end
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (wr_ctrl && i_wb_data[CTRL_OVR]) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read-back
  // ---------------------------------------------------------------------
  // Assemble STATUS; mode shows the running walk while busy, else the shadow
  always_comb begin
    status_word = '0;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_MODE] = busy ? mode_reg : cfg_reg.mode;
    status_word[STAT_DONE] = done_reg;
    status_word[STAT_OVR]  = overrun_reg;
    status_word[STAT_REP_LSB +: REP_W]      = rep_reg;
    status_word[STAT_POS_LSB +: STAT_POS_W] = STAT_POS_W'(pos_reg);
  end

  assign div_word = 32'(div_reg);

  // Acknowledge every request one cycle later with data sampled at accept
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg <= req;
      if (req) begin
        rdata_reg <= (i_wb_addr == ADDR_DIV) ? div_word : status_word;
      end else begin
        rdata_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ledwalker_wb.sv
// Directed bench for ledwalker_wb (NLEDS=8, DEFAULT_DIV=3): bus walks,
// repeats, overrun, button starts, DIV changes and asynchronous reset.
module tb_ledwalker_wb;

  localparam int NLEDS = 8;
  localparam int DIV_W = 24;

  logic             clk;
  logic             rst_n;
  logic             btn;
  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic             wb_addr;
  logic [31:0]      wb_wdata;
  logic             wb_stall;
  logic             wb_ack;
  logic [31:0]      wb_rdata;
  logic [NLEDS-1:0] led;
  logic             irq;

  int n_checks;
  int n_pass;

  ledwalker_wb #(
    .NLEDS       (NLEDS),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (3)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_btn      (btn),
    .i_wb_cyc   (wb_cyc),
    .i_wb_stb   (wb_stb),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_wdata),
    .o_wb_stall (wb_stall),
    .o_wb_ack   (wb_ack),
    .o_wb_data  (wb_rdata),
    .o_led      (led),
    .o_int      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge; it is accepted at the next posedge and
  // the ack is sampled at the following negedge
  task automatic bus_write(input logic addr, input logic [31:0] data);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = addr; wb_wdata = data;
    @(negedge clk);
    check("wr_ack", 32'(wb_ack), 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_wdata = '0;
    $display("wr addr=%0d data=0x%08h", addr, data);
  endtask

  task automatic rd_expect(input string tag, input logic addr, input logic [31:0] exp);
    logic [31:0] got;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = addr;
    @(negedge clk);
    check({tag, "_ack"}, 32'(wb_ack), 32'd1);
    got = wb_rdata;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    $display("rd addr=%0d data=0x%08h", addr, got);
    check(tag, got, exp);
  endtask

  // Checks every cycle of a walk from the current negedge (walk cycle
  // 'skip'), then the completion cycle and the end of the pulse
  task automatic walk_check(input string tag, input bit oneway, input int reps,
                            input int div, input int skip);
    int          seq[$];
    logic [31:0] one;
    one = 32'd1;
    for (int r = 0; r <= reps; r++) begin
      for (int p = 0; p < NLEDS; p++)
        for (int h = 0; h <= div; h++) seq.push_back(p);
      if (!oneway)
        for (int p = NLEDS - 2; p >= 0; p--)
          for (int h = 0; h <= div; h++) seq.push_back(p);
    end
    for (int i = skip; i < seq.size(); i++) begin
      check({tag, "_led"}, 32'(led), one << seq[i]);
      @(negedge clk);
    end
    check({tag, "_end_led"}, 32'(led), 32'd0);
    check({tag, "_end_int"}, 32'(irq), 32'd1);
    @(negedge clk);
    check({tag, "_int_once"}, 32'(irq), 32'd0);
  endtask

  initial begin
    int          fast_seq[$];
    logic [31:0] one;
    one = 32'd1;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; btn = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 1'b0; wb_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_int", 32'(irq), 32'd0);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_data", wb_rdata, 32'd0);
    check("stall", 32'(wb_stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_expect("rst_div", 1'b1, 32'd3);
    rd_expect("rst_status", 1'b0, 32'h0);

    // Bounce walk
    bus_write(1'b0, 32'h01);
    walk_check("bounce", 1'b0, 0, 3, 0);
    rd_expect("bounce_status", 1'b0, 32'h04);
    bus_write(1'b0, 32'h04);
    rd_expect("done_clr", 1'b0, 32'h00);

    // One-way, three passes
    bus_write(1'b0, 32'h23);
    walk_check("oneway", 1'b1, 2, 3, 0);
    // Same walk again, clearing DONE in the start write, sampling the repeat count
    bus_write(1'b0, 32'h27);
    rd_expect("rep2", 1'b0, 32'h23);
    repeat (31) @(negedge clk);
    rd_expect("rep1", 1'b0, 32'h13);
    repeat (31) @(negedge clk);
    rd_expect("rep0", 1'b0, 32'h03);
    repeat (31) @(negedge clk);
    check("rep_end_led", 32'(led), 32'd0);
    check("rep_end_int", 32'(irq), 32'd1);
    rd_expect("oneway_status", 1'b0, 32'h06);
    bus_write(1'b0, 32'h04);
    rd_expect("cfg_back", 1'b0, 32'h00);

    // Start while busy
    bus_write(1'b0, 32'h01);
    repeat (10) @(negedge clk);
    bus_write(1'b0, 32'h01);
    walk_check("ovr_walk", 1'b0, 0, 3, 11);
    rd_expect("ovr_status", 1'b0, 32'h0C);
    bus_write(1'b0, 32'h08);
    rd_expect("ovr_clr", 1'b0, 32'h04);
    bus_write(1'b0, 32'h04);

    // Held button: one walk, LED0 three cycles after the edge
    btn = 1'b1;
    fork
      begin
        repeat (50) @(negedge clk);
        btn = 1'b0;
      end
    join_none
    @(negedge clk);
    @(negedge clk);
    check("btn_lat", 32'(led), 32'd0);
    @(negedge clk);
    walk_check("btn", 1'b0, 0, 3, 0);
    repeat (5) @(negedge clk);
    check("btn_single", 32'(led), 32'd0);
    rd_expect("btn_status", 1'b0, 32'h04);
    bus_write(1'b0, 32'h04);

    // Button and bus start in the same cycle: bus config, no overrun
    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(1'b0, 32'h03);
    check("tie_led0", 32'(led), 32'h01);
    rd_expect("tie_busy", 1'b0, 32'h03);
    repeat (31) @(negedge clk);
    check("tie_end_led", 32'(led), 32'd0);
    check("tie_end_int", 32'(irq), 32'd1);
    rd_expect("tie_status", 1'b0, 32'h06);
    btn = 1'b0;
    bus_write(1'b0, 32'h04);

    // DIV lowered to 0 during the third step
    bus_write(1'b0, 32'h01);
    repeat (9) @(negedge clk);
    bus_write(1'b1, 32'h0);
    check("div_cur", 32'(led), 32'h04);
    fast_seq = '{3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    foreach (fast_seq[i]) begin
      @(negedge clk);
      check("div_fast_led", 32'(led), one << fast_seq[i]);
    end
    @(negedge clk);
    check("div_end_led", 32'(led), 32'd0);
    check("div_end_int", 32'(irq), 32'd1);
    rd_expect("div_rd0", 1'b1, 32'd0);
    bus_write(1'b1, 32'hFF00_0005);
    rd_expect("div_upper", 1'b1, 32'h0000_0005);
    bus_write(1'b0, 32'h04);

    // Asynchronous reset mid-walk
    bus_write(1'b0, 32'h01);
    repeat (5) @(negedge clk);
    check("pre_rst_led", 32'(led), 32'h01);
    rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_int", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_led", 32'(led), 32'd0);
    rd_expect("post_rst_div", 1'b1, 32'd3);
    rd_expect("post_rst_status", 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ledwalker_wb.md
# ledwalker_wb

Parametrised bus-controlled LED walker: sweeps a single lit LED across `NLEDS` outputs, either bouncing or one-way, at a programmable step rate, for a programmable number of repeats. It sits on the Wishbone pipeline bus as a two-register slave and also accepts a synchronised push-button request. It reports busy, done, overrun, live position and a one-cycle completion pulse.

## Interface
- `NLEDS`, 8, number of LEDs; legal range 2..256.
- `DIV_W`, 24, width of the step divider register; legal range 1..32.
- `DEFAULT_DIV`, 5_000_000, reset value of DIV. Each step lasts DIV+1 clocks.
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_btn`  in  1  raw push-button, asynchronous to `i_clk`.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`  in  1 each  Wishbone pipeline controls.
- `i_wb_addr`  in  1  register select: 0 = CTRL/STATUS, 1 = DIV.
- `i_wb_data`  in  32  write data.
- `o_wb_stall`  out  1  tied 0.
- `o_wb_ack`  out  1  acknowledge.
- `o_wb_data`  out  32  read data.
- `o_led`  out  NLEDS  one-hot walking LED; all zero when idle.
- `o_int`  out  1  one-cycle pulse at walk completion.

## Operation
- Request: a request is a bus cycle with `i_wb_stb && i_wb_cyc`.
- CTRL write bits:
  - [0] START.
  - [1] MODE: 0 = bounce, 1 = one-way.
  - [2] W1C DONE.
  - [3] W1C OVERRUN.
  - [7:4] REPEAT.
- A CTRL write always latches MODE and REPEAT into a shadow config.
- STATUS read bits:
  - [0] busy.
  - [1] MODE.
  - [2] DONE (sticky).
  - [3] OVERRUN (sticky).
  - [7:4] repeats remaining.
  - [15:8] position index.
  - All other bits read 0.
- DIV register: read/write, bits [DIV_W-1:0]; upper bits are ignored on write and read as 0.
- Position sequence:
  - Bounce: 0,1,…,NLEDS-1,…,1,0, which is 2·NLEDS-1 steps.
  - One-way: 0…NLEDS-1, which is NLEDS steps.
  - `o_led` = 1 << position while busy.
- Repeat: the pass is performed REPEAT+1 times. Passes run back-to-back with no idle cycle. In bounce mode this means LED0 is held for two consecutive steps at the pass boundary.
- Start sources:
  - CTRL write with START=1.
  - Rising edge of the synchronised button, which uses the shadow config.
- Start arbitration:
  - If bus and button start in the same cycle, the bus wins and the button event is dropped without a flag.
  - Any start while busy is ignored and sets OVERRUN. All other fields of that write still apply, including W1C bits and the shadow config.
- Writing 1 to DONE/OVERRUN in the same cycle that hardware sets the flag: the set wins.
- Step counter:
  - Reset to 0 at every step start.
  - The step ends when count ≥ live DIV.
  - Lowering DIV mid-step ends that step on the next cycle.
- Button path: 2-FF synchroniser plus a third flop for edge detect. A held button produces exactly one start.
- Reset (asynchronous, any time, including mid-walk) clears everything immediately:
  - `o_led`=0, `o_int`=0, `o_wb_ack`=0, `o_wb_data`=0.
  - busy, DONE and OVERRUN = 0.
  - Shadow config = bounce, REPEAT=0.
  - DIV = DEFAULT_DIV.
  - Synchroniser flops = 0.

## Timing
- Bus acknowledge: a request accepted at edge T gives `o_wb_ack`=1 for one cycle at T+1. `o_wb_data` is valid with it and reflects state sampled at T. The bus never stalls.
- Bus start: accepted at T gives busy=1, position 0 and `o_led`[0]=1, all visible at T+1.
- Button start: `i_btn` rising before edge T gives `o_led`[0]=1 visible at T+3.
- Step length: each position holds exactly DIV+1 cycles. DIV=0 advances every cycle.
- Completion: the cycle after the final position's last hold cycle shows busy=0, `o_led`=0, `o_int`=1 (one cycle) and DONE=1.
- A new start is accepted from the first idle cycle onward.

## Structure
- Package `ledwalk_pkg`:
  - Register addresses.
  - CTRL/STATUS bit indices.
  - Mode encoding.
  - Width of the repeat field.
- Sub-module `walk_step_div`: the step counter. Inputs: clock, reset, run, DIV. Output: step pulse.
- Top level holds:
  - Bus decode.
  - Sticky flags.
  - Synchroniser.
  - Position/direction/repeat FSM, with states IDLE, UP, DOWN.
  - Registered one-hot decode.

## Test plan
All scenarios use NLEDS=8, DEFAULT_DIV=3.
- Bounce walk: write CTRL=0x01 → `o_led` sequence 0x01,0x02,…,0x80,…,0x01, each held 4 cycles; busy for 60 cycles; `o_int` pulses once; STATUS reads 0x04.
- One-way with repeats: write CTRL=0x23 → 0x01…0x80 three times with no gap; busy for 96 cycles; STATUS[7:4] counts 2,1,0.
- Start while busy: write 0x01 at cycle 10 of a walk → the walk continues unchanged; STATUS[3]=1. A following write of 0x08 → STATUS[3]=0.
- Button: hold `i_btn` high for 50 cycles → exactly one walk starts, with `o_led`=0x01 three cycles after the edge. Simultaneous button and bus start → one walk, bus MODE used, no OVERRUN.
- DIV update: write DIV=0 during step 2 → remaining steps last 1 cycle each; reading DIV returns 0.
- Reset: deassert `i_reset_n` mid-walk → `o_led`=0 and busy=0 immediately; after release, DIV reads 3 and STATUS reads 0.
